// File: rtl/dmem_copy_engine.sv
// Single-request block copier on the data-memory port: reads LEN words from SRC, writes them to DST
// in ascending order, and XOR-folds each copied word into a checksum.
module dmem_copy_engine #(
   parameter int AW        = 10,
   parameter int DW        = 64,
   parameter int LW        = 10,
   parameter int ADDR_STEP = 1,
   parameter int READ_LAT  = 1
) (
   input  logic          clk,
   input  logic          reset_b,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] checksum,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_dout
);

   localparam logic [AW-1:0] STEP    = AW'(ADDR_STEP);
   localparam logic [1:0]    WT_LAST = 2'((READ_LAT >= 2) ? READ_LAT - 2 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WT,
      S_CAP,
      S_WR,
      S_DONE
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [AW-1:0] cur_src;
   logic [AW-1:0] cur_dst;
   logic [LW-1:0] remaining;
   logic [DW-1:0] buffer;
   logic [1:0]    wait_cnt;
   logic [AW-1:0] addr_hold;
   logic [DW-1:0] din_hold;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) state <= S_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = (len != '0) ? S_RD : S_DONE;
         S_RD: begin
            if (READ_LAT == 0)      next_state = S_WR;
            else if (READ_LAT == 1) next_state = S_CAP;
            else                    next_state = S_WT;
         end
         S_WT:    if (wait_cnt == WT_LAST) next_state = S_CAP;
         S_CAP:   next_state = S_WR;
         S_WR:    next_state = (remaining == LW'(1)) ? S_DONE : S_RD;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Address and write data fall back to the last driven value whenever no access is in flight.
   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      mem_read  = (state == S_RD);
      mem_write = (state == S_WR);
      mem_addr  = addr_hold;
      mem_din   = din_hold;
      if (state == S_RD) mem_addr = cur_src;
      if (state == S_WR) begin
         mem_addr = cur_dst;
         mem_din  = buffer;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         cur_src   <= '0;
         cur_dst   <= '0;
         remaining <= '0;
         buffer    <= '0;
         wait_cnt  <= '0;
         checksum  <= '0;
         addr_hold <= '0;
         din_hold  <= '0;
      end else begin
         addr_hold <= mem_addr;
         din_hold  <= mem_din;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cur_src   <= src_addr;
                  cur_dst   <= dst_addr;
                  remaining <= len;
                  checksum  <= '0;
               end
            end
            S_RD: begin
               wait_cnt <= '0;
               if (READ_LAT == 0) buffer <= mem_dout;
            end
            S_WT:  wait_cnt <= wait_cnt + 2'd1;
            S_CAP: buffer <= mem_dout;
            S_WR: begin
               checksum  <= checksum ^ buffer;
               cur_src   <= cur_src + STEP;
               cur_dst   <= cur_dst + STEP;
               remaining <= remaining - LW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine: a one-cycle-latency memory model plus a word-by-word reference copy
// of the memory image used to predict contents, checksum, access counts and completion time.
module tb_dmem_copy_engine;

   localparam int AW    = 10;
   localparam int DW    = 64;
   localparam int LW    = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_b = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [LW-1:0] len = '0;
   logic          busy;
   logic          done;
   logic [DW-1:0] checksum;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_dout;

   logic [DW-1:0] dmem    [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] rd_q;

   int checks = 0;
   int errors = 0;
   int both_high = 0;

   dmem_copy_engine #(.AW(AW), .DW(DW), .LW(LW), .ADDR_STEP(1), .READ_LAT(1)) dut (
      .clk(clk), .reset_b(reset_b), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .checksum(checksum),
      .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_read(mem_read), .mem_write(mem_write), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   assign mem_dout = rd_q;

   always @(posedge clk) begin
      if (mem_read) rd_q <= dmem[mem_addr];
      if (mem_write) dmem[mem_addr] <= mem_din;
      if (mem_read && mem_write) both_high <= both_high + 1;
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_image(input string tag);
      int mism = 0;
      for (int i = 0; i < DEPTH; i++)
         if (dmem[i] !== ref_mem[i]) mism++;
      check_output(tag, 64'(mism), 64'd0);
   endtask

   // Runs one transfer; poke_cyc >= 1 re-pulses start (with a different src) during that busy cycle.
   task automatic apply_stimulus(input logic [AW-1:0] s, input logic [AW-1:0] d,
                                 input logic [LW-1:0] n, input int poke_cyc);
      logic [63:0] exp_sum = '0;
      int rd_cnt = 0;
      int wr_cnt = 0;
      int cyc;
      int limit = 3 * int'(n) + 10;
      for (int i = 0; i < int'(n); i++) begin
         logic [63:0] w;
         w = ref_mem[(int'(s) + i) % DEPTH];
         ref_mem[(int'(d) + i) % DEPTH] = w;
         exp_sum ^= w;
      end
      @(posedge clk); #1;
      start = 1'b1; src_addr = s; dst_addr = d; len = n;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      check_output("busy_after_accept", 64'(busy), 64'd1);
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      while (!done && cyc < limit) begin
         if (cyc == poke_cyc) begin
            start = 1'b1;
            src_addr = AW'(10'h050);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
         if (mem_read) rd_cnt++;
         if (mem_write) wr_cnt++;
      end
      start = 1'b0;
      check_output("done_seen", 64'(done), 64'd1);
      check_output("done_cycle", 64'(cyc), 64'(3 * int'(n) + 1));
      check_output("read_count", 64'(rd_cnt), 64'(n));
      check_output("write_count", 64'(wr_cnt), 64'(n));
      check_output("checksum", checksum, exp_sum);
      @(posedge clk); #1;
      check_output("done_pulse_width", 64'(done), 64'd0);
      check_output("busy_after_done", 64'(busy), 64'd0);
      check_output("checksum_hold", checksum, exp_sum);
      check_image("mem_image");
   endtask

   initial begin
      int cyc;
      int wr_cnt;
      for (int i = 0; i < DEPTH; i++) begin
         dmem[i]    = {$urandom, $urandom};
         ref_mem[i] = dmem[i];
      end
      for (int i = 0; i < 4; i++) begin
         dmem[i]    = 64'(i + 1);
         ref_mem[i] = 64'(i + 1);
      end

      $display("[TB] reset");
      reset_b = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_b = 1'b1;
      check_output("rst_busy", 64'(busy), 64'd0);
      check_output("rst_done", 64'(done), 64'd0);
      check_output("rst_mem_read", 64'(mem_read), 64'd0);
      check_output("rst_mem_write", 64'(mem_write), 64'd0);
      check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
      check_output("rst_mem_din", mem_din, 64'd0);
      check_output("rst_checksum", checksum, 64'd0);

      $display("[TB] basic copy of four words");
      apply_stimulus(10'h000, 10'h010, 10'd4, -1);
      check_output("basic_checksum_value", checksum, 64'h4);

      $display("[TB] zero-length request");
      apply_stimulus(10'h123, 10'h234, 10'd0, -1);

      $display("[TB] source address wrap");
      apply_stimulus(10'h3FE, 10'h100, 10'd4, -1);

      $display("[TB] start while busy is ignored");
      apply_stimulus(10'h020, 10'h080, 10'd6, 3);

      $display("[TB] forward overlap");
      apply_stimulus(10'h200, 10'h202, 10'd6, -1);

      $display("[TB] random transfers");
      for (int t = 0; t < 5; t++)
         apply_stimulus(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
                        LW'($urandom_range(1, 24)), -1);

      $display("[TB] reset during second write");
      ref_mem[10'h340] = ref_mem[10'h300];
      @(posedge clk); #1;
      start = 1'b1; src_addr = 10'h300; dst_addr = 10'h340; len = 10'd8;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      wr_cnt = 0;
      while (wr_cnt < 2 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (mem_write) wr_cnt++;
      end
      check_output("abort_point_reached", 64'(wr_cnt), 64'd2);
      reset_b = 1'b0;
      #1;
      check_output("abort_busy", 64'(busy), 64'd0);
      check_output("abort_done", 64'(done), 64'd0);
      check_output("abort_mem_read", 64'(mem_read), 64'd0);
      check_output("abort_mem_write", 64'(mem_write), 64'd0);
      check_output("abort_mem_addr", 64'(mem_addr), 64'd0);
      check_output("abort_mem_din", mem_din, 64'd0);
      check_output("abort_checksum", checksum, 64'd0);
      repeat (2) @(posedge clk);
      #1 reset_b = 1'b1;
      check_image("abort_mem_image");
      apply_stimulus(10'h050, 10'h060, 10'd5, -1);

      check_output("never_read_and_write", 64'(both_high), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
